dbus_responder: RTL and testbench

DBUS_RESPONDER -- requirements
Module: dbus_responder

---
 rtl/common.sv | 38 +++
 rtl/dbus_sram.sv | 30 +++
 rtl/dbus_responder.sv | 116 +++++++++++
 tb/tb_dbus_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// rtl/common.sv - shared data-bus types, responder FSM states and LFSR helper.
package common;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;
    typedef logic [7:0]  u8;

    typedef struct packed {
        logic       valid;
        u32         addr;
        logic [2:0] size;
        u8          strobe;
        u64         data;
    } dbus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u64   data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    // Wide enough for LATENCY (<=15) plus up to 3 random extra cycles.
    localparam int CNT_W = 5;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/dbus_sram.sv
// rtl/dbus_sram.sv - single-port 64-bit store, byte-masked synchronous write, combinational read.
module dbus_sram
    import common::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  u8                        wmask,
    input  u64                       wdata,
    output u64                       rdata
);

    u64 mem [DEPTH];

    // No reset: contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dbus_responder.sv
// rtl/dbus_responder.sv - data-bus responder with fixed latency; DBUS_RESP_RANDOM_DELAY_EN adds 0..3 LFSR wait cycles.
module dbus_responder
    import common::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int AW = $clog2(DEPTH);

    resp_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, load;
    logic [AW-1:0]    cap_idx;
    u8                cap_strobe;
    u64               cap_data;
    u64               rdata;
    logic             accept, commit;
    logic             unused_req;

    assign unused_req = ^{dreq.size, dreq.addr};

`ifdef DBUS_RESP_RANDOM_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (accept) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign load = CNT_W'(LATENCY) + {{(CNT_W-2){1'b0}}, lfsr[1:0]};
`else
    assign load = CNT_W'(LATENCY);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_idx    <= '0;
            cap_strobe <= '0;
            cap_data   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                cap_idx    <= dreq.addr[3 +: AW];
                cap_strobe <= dreq.strobe;
                cap_data   <= dreq.data;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (reset && dreq.valid) begin
                    accept  = 1'b1;
                    cnt_n   = load;
                    state_n = (load == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!dreq.valid) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        state_n = RESP;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
                // A dropped valid here is an abort: no write, no data_ok.
                commit  = reset && dreq.valid;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = accept;
        dresp.data_ok = commit;
        dresp.data    = commit ? rdata : '0;
    end

    dbus_sram #(
        .DEPTH(DEPTH)
    ) u_sram (
        .clk  (clk),
        .we   (commit && (cap_strobe != 8'h00)),
        .addr (cap_idx),
        .wmask(cap_strobe),
        .wdata(cap_data),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_dbus_responder.sv
// tb/tb_dbus_responder.sv - randomized bench for dbus_responder against a word-array reference model.
module tb_dbus_responder;
    import common::*;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
    localparam int AW      = $clog2(DEPTH);
`ifdef DBUS_RESP_RANDOM_DELAY_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif
    localparam u64 PRE = 64'h0123_4567_0000_0000;

    logic       clk;
    logic       rst_n;
    dbus_req_t  dreq;
    dbus_resp_t dresp;

    dbus_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk  (clk),
        .reset(rst_n),
        .dreq (dreq),
        .dresp(dresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    u64 model_mem   [DEPTH];
    bit model_known [DEPTH];

    bit active   = 1'b0;
    int t_acc    = -100;
    int exp_idx;
    u8  exp_strobe;
    u64 exp_wdata;
    u64 exp_data;
    bit exp_known;
    u64 resp_data;
    int resp_lat;
    int resp_cyc;
    int vectors  = 0;
    int errors   = 0;

    task automatic check(input string name, input u64 act, input u64 exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Compare process: every cycle, outputs against what the outstanding request implies.
    always @(negedge clk) begin
        int lo, hi;
        lo = t_acc + LATENCY + 1;
        hi = lo + EXTRA;
        check("addr_ok", u64'(dresp.addr_ok), u64'(rst_n && active && cyc == t_acc));
        if (!(rst_n && active && cyc >= lo && cyc < hi)) begin
            check("data_ok", u64'(dresp.data_ok), u64'(rst_n && active && cyc == hi));
        end
        if (rst_n && active && dresp.data_ok && cyc >= lo && cyc <= hi) begin
            if (exp_known) check("resp_data", dresp.data, exp_data);
            resp_data = dresp.data;
            resp_lat  = cyc - t_acc;
            resp_cyc  = cyc;
            for (int b = 0; b < 8; b++) begin
                if (exp_strobe[b]) model_mem[exp_idx][8*b +: 8] = exp_wdata[8*b +: 8];
            end
            if (exp_strobe == 8'hFF) model_known[exp_idx] = 1'b1;
            active = 1'b0;
        end else begin
            check("idle_data", dresp.data, 64'h0);
        end
    end

    task automatic issue(input u32 a, input u8 s, input u64 d);
        int idx;
        idx         = int'(a[3 +: AW]);
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = 3'($urandom);
        dreq.strobe = s;
        dreq.data   = d;
        exp_idx     = idx;
        exp_strobe  = s;
        exp_wdata   = d;
        exp_data    = model_mem[idx];
        exp_known   = model_known[idx];
        t_acc       = cyc;
        active      = 1'b1;
    endtask

    task automatic txn(input u32 a, input u8 s, input u64 d, input bit hold);
        issue(a, s, d);
        for (int k = 0; k < 40 && active; k++) begin
            @(posedge clk); #1;
            if (active) begin
                dreq.addr   = $urandom;
                dreq.strobe = 8'($urandom);
                dreq.data   = {$urandom, $urandom};
            end
        end
        if (active) begin
            vectors++;
            errors++;
            $display("FAIL timeout: no data_ok for addr %h within 40 cycles", a);
            active = 1'b0;
        end
        if (!hold) dreq.valid = 1'b0;
    endtask

    task automatic abort_txn(input u32 a, input u8 s, input u64 d, input int n);
        issue(a, s, d);
        repeat (n) begin
            @(posedge clk); #1;
        end
        dreq.valid = 1'b0;
        active     = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int c1;
        rst_n = 1'b0;
        dreq  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) begin
            txn(u32'(i) << 3, 8'hFF, PRE | u64'(i), i != DEPTH - 1);
        end

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        txn(32'h10, 8'h00, 64'hFFFF, 1'b0);
`ifndef DBUS_RESP_RANDOM_DELAY_EN
        check("read_latency", u64'(resp_lat), 64'd3);
`endif
        check("read_0x10", resp_data, 64'h0123_4567_0000_0002);

        txn(32'h8, 8'hFF, 64'h0, 1'b0);
        txn(32'h8, 8'h0F, 64'h1122_3344_5566_7788, 1'b0);
        check("partial_wr_resp", resp_data, 64'h0);
        txn(32'h8, 8'h00, 64'h0, 1'b0);
        check("partial_rd", resp_data, 64'h0000_0000_5566_7788);

        txn(32'h2000, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        txn(32'h0, 8'h00, 64'h0, 1'b0);
        check("wrap_rd", resp_data, 64'hDEAD_BEEF_CAFE_F00D);

        issue(32'h28, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0);
        @(posedge clk); #3;
        rst_n  = 1'b0;
        active = 1'b0;
        #1;
        check("rst_addr_ok", u64'(dresp.addr_ok), 64'h0);
        check("rst_data_ok", u64'(dresp.data_ok), 64'h0);
        check("rst_data", dresp.data, 64'h0);
        repeat (2) @(posedge clk);
        #3 dreq.valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(32'h28, 8'h00, 64'h0, 1'b0);
        check("rst_write_lost", resp_data, 64'h0123_4567_0000_0005);

        abort_txn(32'h30, 8'hFF, 64'h5555_5555_5555_5555, 1);
        txn(32'h30, 8'h00, 64'h0, 1'b0);
        check("abort_wait", resp_data, 64'h0123_4567_0000_0006);
`ifndef DBUS_RESP_RANDOM_DELAY_EN
        abort_txn(32'h38, 8'hFF, 64'h7777_7777_7777_7777, LATENCY + 1);
        txn(32'h38, 8'h00, 64'h0, 1'b0);
        check("abort_resp", resp_data, 64'h0123_4567_0000_0007);

        txn(32'h40, 8'h00, 64'h0, 1'b1);
        c1 = resp_cyc;
        txn(32'h48, 8'h00, 64'h0, 1'b0);
        check("b2b_spacing", u64'(resp_cyc - c1), u64'(LATENCY + 2));
        check("b2b_data", resp_data, 64'h0123_4567_0000_0009);
`endif

        for (int n = 0; n < 300; n++) begin
            u32 a;
            u8  s;
            a = ($urandom & 32'hFFFF_E000) | (u32'($urandom_range(0, 15)) << 3) | ($urandom & 32'h7);
            s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            txn(a, s, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
            if (!dreq.valid) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        dreq.valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
